// File: rtl/hyperram_cmd_sequencer_if.sv
// Host-side request and data port of hyperram_cmd_sequencer.
// master = system bus adapter, slave = sequencer.
interface hyperram_cmd_sequencer_if #(
    parameter int W_ADDR     = 32,
    parameter int W_BURSTLEN = 5
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_write;
    logic [W_ADDR-1:0]     req_addr;
    logic [W_BURSTLEN-1:0] req_len;
    logic                  req_done;
    logic                  req_err;
    logic [7:0]            host_wdata;
    logic                  host_wdata_rdy;
    logic [7:0]            host_rdata;
    logic                  host_rdata_vld;

    modport master (
        output req_vld, req_write, req_addr, req_len, host_wdata,
        input  req_rdy, req_done, req_err, host_wdata_rdy, host_rdata, host_rdata_vld
    );

    modport slave (
        input  req_vld, req_write, req_addr, req_len, host_wdata,
        output req_rdy, req_done, req_err, host_wdata_rdy, host_rdata, host_rdata_vld
    );
endinterface

// File: rtl/hyperram_cmd_sequencer.sv
// Issues one HyperBus burst per host request, then counts data beats to completion.
// Optional power-up CR0 write is enabled by defining HYPERRAM_INIT_CR0_EN.
module hyperram_cmd_sequencer #(
    parameter int          W_BURSTLEN = 5,
    parameter int          W_ADDR     = 32,
    parameter logic [15:0] CR0_VALUE  = 16'h8f1f
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hyperram_cmd_sequencer_if.slave host,
    input  logic [3:0]            cfg_latency_i,
    input  logic [3:0]            cfg_recovery_i,
    input  logic [1:0]            cfg_shmoo_i,
    output logic [47:0]           cmd_addr_o,
    output logic                  start_reg_o,
    output logic                  start_data_o,
    input  logic                  start_rdy_i,
    output logic [W_BURSTLEN-1:0] burst_len_o,
    output logic [3:0]            latency_o,
    output logic [3:0]            recovery_o,
    output logic [1:0]            capture_shmoo_o,
    output logic [7:0]            wdata_o,
    input  logic                  wdata_rdy_i,
    input  logic [7:0]            rdata_i,
    input  logic                  rdata_vld_i,
    output logic                  init_done_o
);

    typedef enum logic [2:0] {
        ST_INIT_ISSUE,
        ST_INIT_XFER,
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE
    } state_t;

`ifdef HYPERRAM_INIT_CR0_EN
    localparam state_t               RESET_STATE = ST_INIT_ISSUE;
    localparam logic [47:0]          INIT_CA     = 48'h6000_0100_0000;
    localparam logic [W_BURSTLEN:0]  BEAT_TWO    = (W_BURSTLEN+1)'(2);
`else
    localparam state_t               RESET_STATE = ST_IDLE;
`endif
    localparam logic [W_BURSTLEN:0]  BEAT_ONE    = (W_BURSTLEN+1)'(1);

    state_t                state_q, state_d;
    logic [47:0]           cmd_addr_q, cmd_addr_d;
    logic                  start_data_q, start_data_d;
    logic                  start_reg_q, start_reg_d;
    logic [W_BURSTLEN-1:0] burst_len_q, burst_len_d;
    logic [W_BURSTLEN:0]   beats_q, beats_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic                  init_done_q, init_done_d;

    logic [31:0]           addr_ext;
    logic                  accept;
    logic                  beat;
    logic                  in_init;

    assign addr_ext = 32'(host.req_addr);
    assign accept   = (state_q == ST_IDLE) && init_done_q && host.req_vld;
    assign beat     = wr_q ? wdata_rdy_i : rdata_vld_i;
    assign in_init  = (state_q == ST_INIT_ISSUE) || (state_q == ST_INIT_XFER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            cmd_addr_q   <= '0;
            start_data_q <= 1'b0;
            start_reg_q  <= 1'b0;
            burst_len_q  <= '0;
            beats_q      <= '0;
            wr_q         <= 1'b0;
            err_q        <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_addr_q   <= cmd_addr_d;
            start_data_q <= start_data_d;
            start_reg_q  <= start_reg_d;
            burst_len_q  <= burst_len_d;
            beats_q      <= beats_d;
            wr_q         <= wr_d;
            err_q        <= err_d;
            init_done_q  <= init_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_addr_d   = cmd_addr_q;
        start_data_d = start_data_q;
        start_reg_d  = start_reg_q;
        burst_len_d  = burst_len_q;
        beats_d      = beats_q;
        wr_d         = wr_q;
        err_d        = err_q;
`ifdef HYPERRAM_INIT_CR0_EN
        init_done_d  = init_done_q;
`else
        init_done_d  = 1'b1;
`endif
        case (state_q)
`ifdef HYPERRAM_INIT_CR0_EN
            ST_INIT_ISSUE: begin
                cmd_addr_d  = INIT_CA;
                burst_len_d = W_BURSTLEN'(1);
                if (start_reg_q && start_rdy_i) begin
                    start_reg_d = 1'b0;
                    beats_d     = BEAT_TWO;
                    state_d     = ST_INIT_XFER;
                end else begin
                    start_reg_d = 1'b1;
                end
            end
            ST_INIT_XFER: begin
                if (wdata_rdy_i) begin
                    beats_d = beats_q - BEAT_ONE;
                    if (beats_q == BEAT_ONE) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
`endif
            ST_IDLE: begin
                if (accept) begin
                    wr_d  = host.req_write;
                    err_d = (host.req_len == '0);
                    if (host.req_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        // Memory space, linear burst; the PHY sees this CA until the handshake.
                        cmd_addr_d   = {~host.req_write, 1'b0, 1'b1, addr_ext[31:3],
                                        13'h0, addr_ext[2:0]};
                        burst_len_d  = host.req_len;
                        start_data_d = 1'b1;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (start_data_q && start_rdy_i) begin
                    start_data_d = 1'b0;
                    beats_d      = {burst_len_q, 1'b0};
                    state_d      = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    beats_d = beats_q - BEAT_ONE;
                    if (beats_q == BEAT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign host.req_rdy        = (state_q == ST_IDLE) && init_done_q;
    assign host.req_done       = (state_q == ST_DONE);
    assign host.req_err        = (state_q == ST_DONE) && err_q;
    assign host.host_wdata_rdy = (state_q == ST_XFER) && wr_q && wdata_rdy_i;
    assign host.host_rdata     = rdata_i;
    assign host.host_rdata_vld = (state_q == ST_XFER) && !wr_q && rdata_vld_i;

    assign cmd_addr_o      = cmd_addr_q;
    assign start_reg_o     = start_reg_q;
    assign start_data_o    = start_data_q;
    assign burst_len_o     = burst_len_q;
    assign init_done_o     = init_done_q;
    // CR0 goes out high byte first: two beats remaining selects [15:8].
    assign wdata_o         = (state_q == ST_INIT_XFER)
                             ? (beats_q[1] ? CR0_VALUE[15:8] : CR0_VALUE[7:0])
                             : host.host_wdata;
    assign latency_o       = in_init ? 4'h0 : cfg_latency_i;
    assign recovery_o      = cfg_recovery_i;
    assign capture_shmoo_o = cfg_shmoo_i;

endmodule

// File: tb/tb_hyperram_cmd_sequencer.sv
// Randomized bench for hyperram_cmd_sequencer: a request-level model predicts every output each cycle,
// and directed transactions pin a few literal command addresses and beat counts.
`timescale 1ns/1ps
module tb_hyperram_cmd_sequencer;
    localparam int W_ADDR     = 32;
    localparam int W_BURSTLEN = 5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [3:0]            cfg_latency, cfg_recovery;
    logic [1:0]            cfg_shmoo;
    logic [47:0]           cmd_addr;
    logic                  start_reg, start_data, start_rdy;
    logic [W_BURSTLEN-1:0] burst_len;
    logic [3:0]            latency, recovery;
    logic [1:0]            capture_shmoo;
    logic [7:0]            wdata, rdata;
    logic                  wdata_rdy, rdata_vld, init_done;

    hyperram_cmd_sequencer_if #(.W_ADDR(W_ADDR), .W_BURSTLEN(W_BURSTLEN)) hif ();

    hyperram_cmd_sequencer #(.W_BURSTLEN(W_BURSTLEN), .W_ADDR(W_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .host(hif),
        .cfg_latency_i(cfg_latency), .cfg_recovery_i(cfg_recovery), .cfg_shmoo_i(cfg_shmoo),
        .cmd_addr_o(cmd_addr), .start_reg_o(start_reg), .start_data_o(start_data),
        .start_rdy_i(start_rdy), .burst_len_o(burst_len), .latency_o(latency),
        .recovery_o(recovery), .capture_shmoo_o(capture_shmoo), .wdata_o(wdata),
        .wdata_rdy_i(wdata_rdy), .rdata_i(rdata), .rdata_vld_i(rdata_vld), .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // HyperBus CA for a linear memory burst, built arithmetically from the field positions.
    function automatic logic [47:0] ca_of(input bit wr, input logic [31:0] a);
        logic [63:0] v;
        v = (wr ? 64'd0 : 64'h8000_0000_0000) + 64'h2000_0000_0000
          + (64'(a >> 3) << 16) + 64'(a % 8);
        return v[47:0];
    endfunction

    function automatic void check_reset_vals(input string tag);
        chk({tag, "_req_rdy"},        hif.req_rdy,        0);
        chk({tag, "_req_done"},       hif.req_done,       0);
        chk({tag, "_req_err"},        hif.req_err,        0);
        chk({tag, "_start_data"},     start_data,         0);
        chk({tag, "_start_reg"},      start_reg,          0);
        chk({tag, "_cmd_addr"},       cmd_addr,           0);
        chk({tag, "_burst_len"},      burst_len,          0);
        chk({tag, "_host_wdata_rdy"}, hif.host_wdata_rdy, 0);
        chk({tag, "_host_rdata_vld"}, hif.host_rdata_vld, 0);
        chk({tag, "_init_done"},      init_done,          0);
    endfunction

    // Request-level model state
    bit          m_init, m_busy, m_wait_hs, m_xfer, m_done, m_err;
    bit          m_cur_wr;
    logic [31:0] m_cur_addr;
    int          m_cur_len, m_rem;
    int          n_rbeats = 0, n_wbeats = 0, n_sd = 0, n_err = 0, n_done = 0, n_hs = 0, n_acc_nz = 0;
    bit          hold_start = 0;

    // Compare process: outputs are sampled mid-cycle, then the model advances past the next edge.
    initial begin
        bit exp_rdy, nd, ne;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_reset_vals("rst");
                m_init = 0; m_busy = 0; m_wait_hs = 0; m_xfer = 0; m_done = 0; m_err = 0; m_rem = 0;
            end else begin
                exp_rdy = m_init && !m_busy;
                chk("req_rdy",        hif.req_rdy,        exp_rdy);
                chk("req_done",       hif.req_done,       m_done);
                chk("req_err",        hif.req_err,        m_done && m_err);
                chk("start_data",     start_data,         m_wait_hs);
                chk("start_reg",      start_reg,          0);
                chk("init_done",      init_done,          m_init);
                chk("host_wdata_rdy", hif.host_wdata_rdy, m_xfer && m_cur_wr && wdata_rdy);
                chk("host_rdata_vld", hif.host_rdata_vld, m_xfer && !m_cur_wr && rdata_vld);
                chk("host_rdata",     hif.host_rdata,     rdata);
                chk("wdata",          wdata,              hif.host_wdata);
                chk("timing_cfg",     {latency, recovery, capture_shmoo},
                                      {cfg_latency, cfg_recovery, cfg_shmoo});
                if (m_wait_hs) begin
                    chk("cmd_addr",  cmd_addr,  ca_of(m_cur_wr, m_cur_addr));
                    chk("burst_len", burst_len, m_cur_len);
                end
                if (hif.host_rdata_vld) n_rbeats++;
                if (hif.host_wdata_rdy) n_wbeats++;
                if (start_data)         n_sd++;
                if (hif.req_err)        n_err++;

                nd = 0; ne = 0;
                if (m_done) begin
                    m_busy = 0;
                    n_done++;
                    $display("txn %0d: wr=%0d addr=%08h len=%0d err=%0d", n_done, m_cur_wr,
                             m_cur_addr, m_cur_len, m_err);
                end
                if (m_xfer && (m_cur_wr ? wdata_rdy : rdata_vld)) begin
                    m_rem--;
                    if (m_rem == 0) begin m_xfer = 0; nd = 1; end
                end
                if (m_wait_hs && start_rdy) begin
                    m_wait_hs = 0; m_xfer = 1; m_rem = 2 * m_cur_len; n_hs++;
                end
                if (exp_rdy && hif.req_vld) begin
                    m_busy     = 1;
                    m_cur_wr   = hif.req_write;
                    m_cur_addr = 32'(hif.req_addr);
                    m_cur_len  = int'(hif.req_len);
                    if (m_cur_len == 0) begin nd = 1; ne = 1; end
                    else begin m_wait_hs = 1; n_acc_nz++; end
                end
                m_done = nd;
                m_err  = ne;
                m_init = 1;
            end
        end
    end

    // PHY stand-in: random start acknowledge and data strobes, including strobes outside bursts.
    initial begin
        start_rdy = 0; wdata_rdy = 0; rdata_vld = 0; rdata = 0;
        forever begin
            @(posedge clk); #1;
            start_rdy = hold_start ? 1'b0 : ($urandom_range(0, 3) != 0);
            wdata_rdy = ($urandom_range(0, 2) != 0);
            rdata_vld = ($urandom_range(0, 2) != 0);
            rdata     = 8'($urandom);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            hif.host_wdata = 8'($urandom);
        end
    end

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk);
            if (hif.req_rdy) break;
            t++;
            if (t > 2000) begin chk("accept_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        hif.req_vld = 0;
    endtask

    task automatic send(input bit wr, input logic [31:0] a, input int len);
        hif.req_write = wr;
        hif.req_addr  = W_ADDR'(a);
        hif.req_len   = W_BURSTLEN'(len);
        hif.req_vld   = 1;
        wait_accept();
    endtask

    task automatic wait_idle();
        int t = 0;
        forever begin
            @(posedge clk);
            if (!m_busy) break;
            t++;
            if (t > 3000) begin chk("idle_timeout", 1, 0); break; end
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_r, b_w, b_sd, b_err, b_done, b_hs, t, len;
        rst_n = 0;
        hif.req_vld = 0; hif.req_write = 0; hif.req_addr = 0; hif.req_len = 0; hif.host_wdata = 0;
        cfg_latency = 4'($urandom); cfg_recovery = 4'($urandom); cfg_shmoo = 2'($urandom);
        repeat (3) @(posedge clk);
        #1;

        // 1: read presented before init_done, held until accepted
        b_r = n_rbeats; b_done = n_done; b_err = n_err;
        hif.req_write = 0; hif.req_addr = W_ADDR'(32'h0000_1234); hif.req_len = 5'd4; hif.req_vld = 1;
        rst_n = 1;
        wait_accept();
        @(negedge clk);
        chk("t1_start_data", start_data, 1);
        chk("t1_cmd_addr",   cmd_addr,   48'hA000_0246_0004);
        chk("t1_burst_len",  burst_len,  4);
        wait_idle();
        chk("t1_rbeats", n_rbeats - b_r,  8);
        chk("t1_done",   n_done - b_done, 1);
        chk("t1_err",    n_err - b_err,   0);

        // 2: single-halfword write
        b_w = n_wbeats;
        send(1, 32'h10, 1);
        @(negedge clk);
        chk("t2_cmd_addr", cmd_addr, 48'h2000_0002_0000);
        wait_idle();
        chk("t2_wbeats", n_wbeats - b_w, 2);

        // 3: zero length is rejected without touching the PHY
        b_sd = n_sd; b_err = n_err; b_done = n_done;
        send(0, 32'h40, 0);
        wait_idle();
        chk("t3_done",   n_done - b_done, 1);
        chk("t3_err",    n_err - b_err,   1);
        chk("t3_no_sd",  n_sd - b_sd,     0);

        // 4: PHY stalls start for 20 cycles
        hold_start = 1;
        b_hs = n_hs;
        send(1, 32'h0000_0abc, 3);
        repeat (20) @(negedge clk);
        chk("t4_start_held", start_data, 1);
        chk("t4_cmd_addr",   cmd_addr,   48'h2000_0157_0004);
        chk("t4_no_hs",      n_hs - b_hs, 0);
        @(posedge clk); #1;
        hold_start = 0;
        wait_idle();
        chk("t4_one_hs", n_hs - b_hs, 1);

        // 5: back-to-back requests with req_vld kept high
        b_done = n_done;
        send(0, $urandom, 2);
        send(1, $urandom, 3);
        wait_idle();
        chk("t5_done", n_done - b_done, 2);

        // 6: reset in the middle of a 16-halfword read
        b_r = n_rbeats;
        send(0, $urandom, 16);
        t = 0;
        while (n_rbeats == b_r && t < 500) begin @(posedge clk); t++; end
        chk("t6_in_xfer", (n_rbeats > b_r), 1);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check_reset_vals("t6");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        b_done = n_done;
        send(0, 32'h0000_2000, 2);
        wait_idle();
        chk("t6_after_reset_done", n_done - b_done, 1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
            send(1'($urandom), $urandom, len);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
            if (i == 40) begin
                cfg_latency = 4'($urandom); cfg_recovery = 4'($urandom); cfg_shmoo = 2'($urandom);
            end
        end
        wait_idle();
        chk("hs_vs_accepts", n_hs, n_acc_nz);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
